cc_sched: RTL and testbench

Sequential front-end for the shared combinational CC calculator (opt[2:0], five 4-bit operands, 10-bit out_n). It accepts operation requests from NUM_REQ independent requesters over valid/ready handshakes and arbitrates them round-robin. It drives the single CC instance from registered inputs, waits a fixed settle time, then captures out_n and returns it with the requester index over a valid/ready result port. CC sits beside this block at the same level of hierarchy, not inside it.

---
 rtl/cc_sched_pkg.sv | 9 +
 rtl/cc_sched_rr_arbiter.sv | 22 ++
 rtl/cc_sched.sv | 94 +++++++++
 tb/tb_cc_sched.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cc_sched_pkg.sv
// cc_sched_pkg: shared types and widths for the CC request scheduler
package cc_sched_pkg;
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;
  localparam int OPT_W = 3;
  localparam int OPND_W = 4;
  localparam int NUM_OPND = 5;
  localparam int RES_W = 10;
  localparam int DATA_W = OPND_W * NUM_OPND;
endpackage

// File: rtl/cc_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set req at or after ptr with wrap
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant
);
  logic [ID_W-1:0] idx;
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cc_sched.sv
// cc_sched: round-robin front-end that drives a shared CC calculator from registered
// inputs, waits CALC_WAIT cycles, and returns the captured result with its requester id
module cc_sched
  import cc_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CALC_WAIT = 1,
  parameter int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [3*NUM_REQ-1:0]   req_opt,
  input  logic [20*NUM_REQ-1:0]  req_data,
  output logic [2:0]             cc_opt,
  output logic [3:0]             cc_in_n0,
  output logic [3:0]             cc_in_n1,
  output logic [3:0]             cc_in_n2,
  output logic [3:0]             cc_in_n3,
  output logic [3:0]             cc_in_n4,
  input  logic [9:0]             cc_out_n,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_W-1:0]        res_id,
  output logic [9:0]             res_data
);
  localparam int CNT_W = $clog2(CALC_WAIT + 1);
  state_e state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, res_id_q, res_id_d, gid;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic res_valid_q, res_valid_d;
  logic [RES_W-1:0] res_data_q, res_data_d;
  logic [OPT_W-1:0] opt_q, opt_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [NUM_REQ-1:0] grant;
  logic accept, done;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req  (req_valid),
    .ptr  (ptr_q),
    .grant(grant)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      opt_q       <= '0;
      opnd_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      opt_q       <= opt_d;
      opnd_q      <= opnd_d;
    end
  always_comb begin
    done = cnt_q == CNT_W'(CALC_WAIT - 1);
    state_d = (state_q == IDLE && accept)    ? CALC :
              (state_q == CALC && done)      ? RESP :
              (state_q == RESP && res_ready) ? IDLE : state_q;
  end
  // req_ready is gated by rst_n so nothing can look accepted while reset is held
  always_comb begin
    gid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) gid = ID_W'(i);
    req_ready   = (state_q == IDLE && rst_n) ? grant : '0;
    accept      = |req_ready;
    ptr_d       = accept ? ((int'(gid) == NUM_REQ - 1) ? '0 : gid + 1'b1) : ptr_q;
    cnt_d       = accept ? '0 : (state_q == CALC) ? cnt_q + 1'b1 : cnt_q;
    opt_d       = accept ? req_opt[int'(gid)*OPT_W +: OPT_W] : opt_q;
    opnd_d      = accept ? req_data[int'(gid)*DATA_W +: DATA_W] : opnd_q;
    res_id_d    = accept ? gid : res_id_q;
    res_valid_d = (state_q == CALC && done) ? 1'b1 :
                  (state_q == RESP && res_ready) ? 1'b0 : res_valid_q;
    res_data_d  = (state_q == CALC && done) ? cc_out_n : res_data_q;
  end
  assign cc_opt    = opt_q;
  assign cc_in_n0  = opnd_q[0*OPND_W +: OPND_W];
  assign cc_in_n1  = opnd_q[1*OPND_W +: OPND_W];
  assign cc_in_n2  = opnd_q[2*OPND_W +: OPND_W];
  assign cc_in_n3  = opnd_q[3*OPND_W +: OPND_W];
  assign cc_in_n4  = opnd_q[4*OPND_W +: OPND_W];
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;
endmodule

// File: tb/tb_cc_sched.sv
// tb_cc_sched: two schedulers (CALC_WAIT 1 and 3) sharing stimulus, checked against a
// transaction-level model every cycle plus hand-computed literal expectations
module tb_cc_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] rv = '0;
  logic [5:0] ropt = '0;
  logic [39:0] rdata = '0;
  logic rr = 1'b0;
  logic [9:0] pert [2];
  logic [1:0] rdy [2];
  logic [2:0] copt [2];
  logic [3:0] cn [2][5];
  logic [9:0] cout [2];
  logic rvalid [2];
  logic [0:0] rid [2];
  logic [9:0] rdat [2];
  int passed = 0, total = 0;
  int cw [2] = '{1, 3};
  int m_left [2];
  bit m_have [2];
  int m_ptr [2];
  logic [0:0] m_id [2];
  logic [9:0] m_data [2];
  logic [2:0] m_opt [2];
  logic [19:0] m_n [2];
  logic [1:0] gq [$];
  always #5 clk = ~clk;
  function automatic logic [9:0] stub(input logic [2:0] o, input logic [19:0] d);
    return 10'(128 * int'(o) + int'(d[3:0]) + int'(d[7:4]) + int'(d[11:8]) + int'(d[15:12]) + int'(d[19:16]));
  endfunction
  assign cout[0] = stub(copt[0], {cn[0][4], cn[0][3], cn[0][2], cn[0][1], cn[0][0]}) + pert[0];
  assign cout[1] = stub(copt[1], {cn[1][4], cn[1][3], cn[1][2], cn[1][1], cn[1][0]}) + pert[1];
  cc_sched #(.NUM_REQ(2), .CALC_WAIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_ready(rdy[0]), .req_opt(ropt), .req_data(rdata),
    .cc_opt(copt[0]), .cc_in_n0(cn[0][0]), .cc_in_n1(cn[0][1]), .cc_in_n2(cn[0][2]), .cc_in_n3(cn[0][3]),
    .cc_in_n4(cn[0][4]), .cc_out_n(cout[0]), .res_valid(rvalid[0]), .res_ready(rr), .res_id(rid[0]),
    .res_data(rdat[0]));
  cc_sched #(.NUM_REQ(2), .CALC_WAIT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_ready(rdy[1]), .req_opt(ropt), .req_data(rdata),
    .cc_opt(copt[1]), .cc_in_n0(cn[1][0]), .cc_in_n1(cn[1][1]), .cc_in_n2(cn[1][2]), .cc_in_n3(cn[1][3]),
    .cc_in_n4(cn[1][4]), .cc_out_n(cout[1]), .res_valid(rvalid[1]), .res_ready(rr), .res_id(rid[1]),
    .res_data(rdat[1]));
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask
  // Ready owed by an idle block: first valid requester at or after the model pointer
  function automatic logic [1:0] exp_rdy(input int k);
    if (!rst_n || m_have[k] || m_left[k] != 0) return 2'b00;
    for (int o = 0; o < 2; o++)
      if (rv[(m_ptr[k] + o) % 2]) return 2'((1 << ((m_ptr[k] + o) % 2)));
    return 2'b00;
  endfunction
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [1:0] g;
      g = exp_rdy(k);
      if (!rst_n) begin
        m_left[k] = 0; m_have[k] = 0; m_ptr[k] = 0; m_id[k] = '0;
        m_data[k] = '0; m_opt[k] = '0; m_n[k] = '0;
      end else if (m_have[k]) begin
        if (rr) m_have[k] = 0;
      end else if (m_left[k] > 0) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_data[k] = stub(m_opt[k], m_n[k]) + pert[k];
          m_have[k] = 1;
        end
      end else if (g != 0) begin
        int i;
        i = g[1] ? 1 : 0;
        m_opt[k] = ropt[i*3 +: 3];
        m_n[k] = rdata[i*20 +: 20];
        m_id[k] = 1'(i);
        m_ptr[k] = (i + 1) % 2;
        m_left[k] = cw[k];
      end
    end
    #1;
    for (int k = 0; k < 2; k++)
      chk(k == 0 ? "model_cw1" : "model_cw3",
          64'({rdy[k], rvalid[k], rid[k], rdat[k], copt[k], cn[k][4], cn[k][3], cn[k][2], cn[k][1], cn[k][0]}),
          64'({exp_rdy(k), m_have[k], m_id[k], m_data[k], m_opt[k], m_n[k]}));
  end
  initial begin
    bit seen;
    pert[0] = '0;
    pert[1] = '0;
    rv = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", rdy[0], 2'b00);
    chk("rst_outs", {rvalid[0], rid[0], rdat[0], copt[0], cn[0][0], cn[0][4]}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    rv = 2'b01;
    ropt = {3'd7, 3'd3};
    rdata = {4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    @(posedge clk);
    #1;
    chk("single_cc_opt", copt[0], 3'd3);
    chk("single_cc_n0", cn[0][0], 4'd1);
    chk("single_no_early_valid", rvalid[0], 1'b0);
    @(negedge clk);
    rv = 2'b00;
    @(posedge clk);
    #1;
    chk("single_result", {rvalid[0], rid[0], rdat[0]}, {1'b1, 1'b0, 10'd399});
    chk("single_cc_hold", {copt[0], cn[0][0]}, {3'd3, 4'd1});
    chk("cw3_not_yet_t1", rvalid[1], 1'b0);
    @(negedge clk);
    pert[1] = 10'd5;
    @(posedge clk);
    #1;
    chk("cw3_not_yet_t2", rvalid[1], 1'b0);
    @(posedge clk);
    #1;
    chk("cw3_result_t3", {rvalid[1], rdat[1]}, {1'b1, 10'd404});
    @(negedge clk);
    pert[1] = 10'd9;
    rv = 2'b11;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("bp_frozen", {rvalid[0], rid[0], rdat[0], rdy[0], rdat[1], rdy[1]},
          {1'b1, 1'b0, 10'd399, 2'b00, 10'd404, 2'b00});
    end
    @(negedge clk);
    rr = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_consume", {rvalid[0], rdy[0]}, {1'b0, 2'b10});
    gq.push_back(rdy[0]);
    repeat (24) begin
      @(posedge clk);
      #1;
      if (rdy[0] != 2'b00) begin
        chk("cont_onehot", 1'($onehot(rdy[0])), 1'b1);
        gq.push_back(rdy[0]);
      end
    end
    chk("cont_grants", {gq.size() >= 4 ? {gq[0], gq[1], gq[2], gq[3]} : 8'h00}, 8'b10_01_10_01);
    @(negedge clk);
    rv = 2'b00;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rv = 2'b01;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    rv = 2'b00;
    @(posedge clk);
    #1;
    chk("rst_mid_calc", {rvalid[0], rvalid[1]}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    rv = 2'b10;
    #1;
    chk("post_rst_ready", {rdy[0], rdy[1]}, {2'b10, 2'b10});
    @(posedge clk);
    #1;
    chk("post_rst_accept", rdy[0], 2'b00);
    @(posedge clk);
    #1;
    chk("post_rst_result", {rvalid[0], rid[0], rdat[0]}, {1'b1, 1'b1, 10'd931});
    @(negedge clk);
    rv = 2'b00;
    rr = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk);
      #1;
      seen = rvalid[1];
    end
    chk("cw3_reach_resp", seen, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_resp", {rvalid[0], rvalid[1]}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    rr = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      seen = seen | rvalid[0] | rvalid[1];
    end
    chk("no_stale_result", seen, 1'b0);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
